tamagotchi_needs_engine: RTL and testbench

//  Parametrised pet-state core: N_CH independent need levels (health, energy, food, fun, ...).

---
 rtl/tamagotchi_needs_engine.sv | 175 +++++++++++++++++
 tb/tb_tamagotchi_needs_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_needs_engine.sv
// Pet-state core: N_CH need levels that decay on a timer and rise under held requests, with
// NORMAL/TEST/DEAD modes. Define TAMA_SEG7_EN to build the 7-segment decoder for level_sel.
module tamagotchi_needs_engine #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned LVL_W       = 4,
  parameter int unsigned LVL_MIN     = 1,
  parameter int unsigned LVL_MAX     = 10,
  parameter int unsigned LVL_INIT    = 8,
  parameter int unsigned HAPPY_TH    = 5,
  parameter int unsigned DECAY_TICKS = 24,
  parameter int unsigned HOLD_TICKS  = 3,
  parameter int unsigned PRESCALE    = 7500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  input  logic                    test_req,
  output logic                    tick,
  output logic [N_CH*LVL_W-1:0]   levels,
  output logic [$clog2(N_CH)-1:0] sel,
  output logic [LVL_W-1:0]        level_sel,
  output logic                    happy,
  output logic                    dead,
  output logic                    test_mode,
  output logic [6:0]              seg
);
  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned DEC_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_TICKS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_TICKS - 1);
  localparam logic [LVL_W-1:0] L_MIN    = LVL_W'(LVL_MIN);
  localparam logic [LVL_W-1:0] L_MAX    = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] L_INIT   = LVL_W'(LVL_INIT);

  typedef enum logic [1:0] {ModeNormal, ModeTest, ModeDead} mode_e;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  mode_e            mode_q, mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             test_lat_q, test_lat_d;
  logic [LVL_W-1:0] lvl_q [N_CH];
  logic [LVL_W-1:0] lvl_d [N_CH];
  logic [HLD_W-1:0] hold_q [N_CH];
  logic [HLD_W-1:0] hold_d [N_CH];
  logic [DEC_W-1:0] dec_q [N_CH];
  logic [DEC_W-1:0] dec_d [N_CH];
  logic             all_min;

  always_comb begin
    presc_d    = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    tick_d     = (presc_q == PRE_LAST);
    mode_d     = mode_q;
    sel_d      = sel_q;
    test_lat_d = test_lat_q | test_req;
    all_min    = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      lvl_d[i]  = lvl_q[i];
      hold_d[i] = hold_q[i];
      dec_d[i]  = dec_q[i];
      if (lvl_q[i] != L_MIN) all_min = 1'b0;
    end

    // tick_q marks the cycle after a prescaler wrap; all pet state advances on that edge.
    if (tick_q) begin
      test_lat_d = 1'b0;
      if (test_lat_q || test_req) begin
        mode_d = (mode_q == ModeTest) ? ModeNormal : ModeTest;
        for (int i = 0; i < N_CH; i++) begin
          lvl_d[i]  = (mode_q == ModeTest) ? L_INIT : L_MIN;
          hold_d[i] = '0;
          dec_d[i]  = '0;
        end
      end else if (mode_q == ModeNormal && all_min) begin
        mode_d = ModeDead;
      end else if (mode_q != ModeDead) begin
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (req[i]) sel_d = SEL_W'(i);
        end
        for (int i = 0; i < N_CH; i++) begin
          if (req[i]) begin
            if (hold_q[i] == HLD_LAST) begin
              hold_d[i] = '0;
              dec_d[i]  = '0;
              if (mode_q == ModeTest) lvl_d[i] = (lvl_q[i] == L_MIN) ? L_MAX : L_MIN;
              else if (lvl_q[i] != L_MAX) lvl_d[i] = lvl_q[i] + 1'b1;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end else begin
            hold_d[i] = '0;
            if (mode_q == ModeTest || lvl_q[i] == L_MIN) begin
              dec_d[i] = '0;
            end else if (dec_q[i] == DEC_LAST) begin
              dec_d[i] = '0;
              lvl_d[i] = lvl_q[i] - 1'b1;
            end else begin
              dec_d[i] = dec_q[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      mode_q     <= ModeNormal;
      sel_q      <= '0;
      test_lat_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        lvl_q[i]  <= L_INIT;
        hold_q[i] <= '0;
        dec_q[i]  <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      test_lat_q <= test_lat_d;
      for (int i = 0; i < N_CH; i++) begin
        lvl_q[i]  <= lvl_d[i];
        hold_q[i] <= hold_d[i];
        dec_q[i]  <= dec_d[i];
      end
    end
  end

  always_comb begin
    levels = '0;
    for (int i = 0; i < N_CH; i++) levels[i*LVL_W +: LVL_W] = lvl_q[i];
  end

  assign tick      = tick_q;
  assign sel       = sel_q;
  assign level_sel = lvl_q[sel_q];
  assign dead      = (mode_q == ModeDead);
  assign test_mode = (mode_q == ModeTest);
  assign happy     = (32'(level_sel) >= HAPPY_TH) && !dead;

`ifdef TAMA_SEG7_EN
  // Active-low segments, a = bit0; DEAD overrides the digit with a dash.
  always_comb begin
    seg = 7'h7F;
    if (dead) begin
      seg = 7'b0111111;
    end else begin
      case (32'(level_sel))
        32'd0:   seg = 7'b1000000;
        32'd1:   seg = 7'b1111001;
        32'd2:   seg = 7'b0100100;
        32'd3:   seg = 7'b0110000;
        32'd4:   seg = 7'b0011001;
        32'd5:   seg = 7'b0010010;
        32'd6:   seg = 7'b0000010;
        32'd7:   seg = 7'b1111000;
        32'd8:   seg = 7'b0000000;
        32'd9:   seg = 7'b0010000;
        32'd10:  seg = 7'b0001000;
        default: seg = 7'h7F;
      endcase
    end
  end
`else
  assign seg = 7'h7F;
`endif

endmodule

// File: tb/tb_tamagotchi_needs_engine.sv
// Bench for tamagotchi_needs_engine: table of {stimulus, expected state} records pushed through a
// scoreboard queue, plus hand-written tick-period and mid-prescale reset sequences.
module tb_tamagotchi_needs_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic        test_req = 1'b0;
  logic        tick;
  logic [15:0] levels;
  logic [1:0]  sel;
  logic [3:0]  level_sel;
  logic        happy, dead, test_mode;
  logic [6:0]  seg;

  int n_vec = 0;
  int n_miss = 0;

  tamagotchi_needs_engine #(
    .PRESCALE(2), .DECAY_TICKS(4), .HOLD_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .test_req(test_req), .tick(tick),
    .levels(levels), .sel(sel), .level_sel(level_sel), .happy(happy), .dead(dead),
    .test_mode(test_mode), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic        tp;
    logic [7:0]  nt;
    logic [15:0] lv;
    logic [1:0]  sel;
    logic        dead;
    logic        tm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic [3:0] r, logic tp, int nt, int a0, int a1, int a2, int a3,
                              int s, logic d, logic tm);
    vec_t v;
    v.req  = r;
    v.tp   = tp;
    v.nt   = 8'(nt);
    v.lv   = {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    v.sel  = 2'(s);
    v.dead = d;
    v.tm   = tm;
    return v;
  endfunction

  function automatic logic [6:0] seg_exp(logic [3:0] l, logic d);
`ifdef TAMA_SEG7_EN
    logic [6:0] codes [16];
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return d ? 7'b0111111 : codes[l];
`else
    return (d || l == 4'd0) ? 7'h7F : 7'h7F;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input vec_t e);
    logic [15:0] lv;
    logic [3:0]  ls;
    lv = e.lv;
    ls = lv[e.sel*4 +: 4];
    chk({tag, " levels"}, 32'(levels), 32'(lv));
    chk({tag, " sel"}, 32'(sel), 32'(e.sel));
    chk({tag, " level_sel"}, 32'(level_sel), 32'(ls));
    chk({tag, " dead"}, 32'(dead), 32'(e.dead));
    chk({tag, " test_mode"}, 32'(test_mode), 32'(e.tm));
    chk({tag, " happy"}, 32'(happy), 32'((ls >= 4'd5) && !e.dead));
    chk({tag, " seg"}, 32'(seg), 32'(seg_exp(ls, e.dead)));
  endtask

  // Returns at the negedge following the next state-update edge.
  task automatic step_tick();
    int k = 0;
    while (!tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!tick) begin
      n_vec++;
      n_miss++;
      $display("FAIL tick_timeout: got no tick, want one within 20 clk");
    end
    @(negedge clk);
  endtask

  task automatic pulse_test();
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per;
    vec_t e;
    tbl.push_back(mk(4'b0000, 0,  0,  8,  8,  8,  8, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  3,  8,  8,  8,  8, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  1,  7,  7,  7,  7, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 0,  3,  7,  7,  8,  7, 2, 0, 0));
    tbl.push_back(mk(4'b0100, 0,  3,  6,  6,  9,  6, 2, 0, 0));
    tbl.push_back(mk(4'b0100, 0,  3,  5,  5, 10,  5, 2, 0, 0));
    tbl.push_back(mk(4'b0100, 0,  3,  4,  4, 10,  4, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  4,  3,  3,  9,  3, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  8,  1,  1,  7,  1, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  8,  1,  1,  5,  1, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  4,  1,  1,  4,  1, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 12,  1,  1,  1,  1, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  1,  1,  1,  1,  1, 2, 1, 0));
    tbl.push_back(mk(4'b0001, 0, 10,  1,  1,  1,  1, 2, 1, 0));
    tbl.push_back(mk(4'b0000, 1,  1,  1,  1,  1,  1, 2, 0, 1));
    tbl.push_back(mk(4'b0010, 0,  3,  1, 10,  1,  1, 1, 0, 1));
    tbl.push_back(mk(4'b0010, 0,  3,  1,  1,  1,  1, 1, 0, 1));
    tbl.push_back(mk(4'b0000, 1,  1,  8,  8,  8,  8, 1, 0, 0));
    tbl.push_back(mk(4'b1001, 0,  3,  9,  8,  8,  9, 0, 0, 0));
    tbl.push_back(mk(4'b1001, 0,  2,  9,  7,  7,  9, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 0,  1,  9,  7,  7, 10, 3, 0, 0));
    tbl.push_back(mk(4'b0001, 0,  2,  9,  6,  6, 10, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 0,  1, 10,  6,  6, 10, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0,  1, 10,  6,  6,  9, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk("reset tick", 32'(tick), 32'd0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      req = tbl[k].req;
      if (tbl[k].tp) pulse_test();
      sb.push_back(tbl[k]);
      repeat (int'(tbl[k].nt)) step_tick();
      e = sb.pop_front();
      check_state($sformatf("v%0d", k), e);
    end

    // Tick period: two clk between strobes.
    per = 0;
    while (!tick && per < 20) begin @(negedge clk); per++; end
    per = 0;
    @(negedge clk);
    per = 1;
    while (!tick && per < 20) begin @(negedge clk); per++; end
    chk("tick period", 32'(per), 32'd2);
    step_tick();

    // Ch3 held for two ticks (hold==2), then async reset between edges.
    req = 4'b1000;
    step_tick();
    step_tick();
    #2 reset = 1'b1;
    #1;
    check_state("async_rst", mk(4'b1000, 0, 0, 8, 8, 8, 8, 0, 0, 0));
    chk("async_rst tick", 32'(tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step_tick();
    check_state("post_rst t1", mk(4'b1000, 0, 1, 8, 8, 8, 8, 3, 0, 0));
    step_tick();
    check_state("post_rst t2", mk(4'b1000, 0, 1, 8, 8, 8, 8, 3, 0, 0));
    step_tick();
    check_state("post_rst t3", mk(4'b1000, 0, 1, 8, 8, 8, 9, 3, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
